// File: rtl/board_clear_ctrl_if.sv
// Board RAM access port: one registered-read address pair plus one write port.
// Used both for the game-logic side (slave) and the RAM side (master).
interface board_clear_ctrl_if #(
  parameter int unsigned X_W = 4,
  parameter int unsigned Y_W = 5
);
  logic [X_W-1:0] rx;
  logic [Y_W-1:0] ry;
  logic           rdata;
  logic           we;
  logic [X_W-1:0] wx;
  logic [Y_W-1:0] wy;
  logic           wdata;

  modport master (output rx, ry, we, wx, wy, wdata, input rdata);
  modport slave  (input rx, ry, we, wx, wy, wdata, output rdata);
endinterface

// File: rtl/board_clear_ctrl.sv
// Line-clear controller and board-RAM arbiter: removes full rows, compacts the rest downward.
// Optional BOARD_CLEAR_EARLY_EXIT_EN stops the scan at the first empty row and zero-fills from there.
module board_clear_ctrl #(
  parameter int unsigned COLS = 10,
  parameter int unsigned ROWS = 20,
  parameter int unsigned X_W  = 4,
  parameter int unsigned Y_W  = 5
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [2:0]          lines_cleared,
  board_clear_ctrl_if.slave   gl,
  board_clear_ctrl_if.master  mem
);

  typedef enum logic [2:0] {StIdle, StRead, StEval, StCopy, StFill, StDone} state_e;

  localparam logic signed [Y_W:0] TopRow  = (Y_W + 1)'(ROWS - 1);
  localparam logic signed [Y_W:0] One     = (Y_W + 1)'(1);
  localparam logic [X_W:0]        ReadEnd = (X_W + 1)'(COLS);
  localparam logic [X_W:0]        LastCol = (X_W + 1)'(COLS - 1);

  state_e                state_q, state_d;
  logic signed [Y_W:0]   src_q, src_d;
  logic signed [Y_W:0]   dst_q, dst_d;
  logic [COLS-1:0]       rowbuf_q, rowbuf_d;
  logic [X_W:0]          col_q, col_d;
  logic [2:0]            lines_q, lines_d;
  logic                  fill_ok;
  logic                  cur_bit;

  logic [X_W-1:0]        ctl_rx;
  logic [Y_W-1:0]        ctl_ry;
  logic                  ctl_we;
  logic [X_W-1:0]        ctl_wx;
  logic [Y_W-1:0]        ctl_wy;
  logic                  ctl_wdata;

`ifdef BOARD_CLEAR_EARLY_EXIT_EN
  logic signed [Y_W:0]   floor_q, floor_d;
  assign fill_ok = (dst_q >= floor_q);
`else
  assign fill_ok = ~dst_q[Y_W];
`endif

  assign busy          = (state_q != StIdle);
  assign lines_cleared = lines_q;

  always_comb begin
    cur_bit = 1'b0;
    for (int unsigned k = 0; k < COLS; k++) begin
      if (col_q == (X_W + 1)'(k)) cur_bit = rowbuf_q[k];
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rowbuf_d  = rowbuf_q;
    col_d     = col_q;
    lines_d   = lines_q;
`ifdef BOARD_CLEAR_EARLY_EXIT_EN
    floor_d   = floor_q;
`endif
    done      = 1'b0;
    ctl_rx    = col_q[X_W-1:0];
    ctl_ry    = src_q[Y_W-1:0];
    ctl_we    = 1'b0;
    ctl_wx    = col_q[X_W-1:0];
    ctl_wy    = dst_q[Y_W-1:0];
    ctl_wdata = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = TopRow;
          dst_d   = TopRow;
          lines_d = '0;
          col_d   = '0;
`ifdef BOARD_CLEAR_EARLY_EXIT_EN
          floor_d = '0;
`endif
          state_d = StRead;
        end
      end
      StRead: begin
        // Data for column k arrives while col_q is k+1.
        for (int unsigned k = 0; k < COLS; k++) begin
          if (col_q == (X_W + 1)'(k + 1)) rowbuf_d[k] = mem.rdata;
        end
        if (col_q == ReadEnd) begin
          col_d   = '0;
          state_d = StEval;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      StEval: begin
        if (&rowbuf_q) begin
          if (lines_q != 3'd7) lines_d = lines_q + 3'd1;
          src_d   = src_q - One;
          state_d = src_d[Y_W] ? StFill : StRead;
`ifdef BOARD_CLEAR_EARLY_EXIT_EN
        end else if (rowbuf_q == '0) begin
          floor_d = src_q;
          state_d = StFill;
`endif
        end else if (dst_q == src_q) begin
          dst_d   = dst_q - One;
          src_d   = src_q - One;
          state_d = src_d[Y_W] ? StFill : StRead;
        end else begin
          state_d = StCopy;
        end
      end
      StCopy: begin
        ctl_we    = 1'b1;
        ctl_wdata = cur_bit;
        if (col_q == LastCol) begin
          col_d   = '0;
          dst_d   = dst_q - One;
          src_d   = src_q - One;
          state_d = src_d[Y_W] ? StFill : StRead;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      StFill: begin
        if (fill_ok) begin
          ctl_we = 1'b1;
          if (col_q == LastCol) begin
            col_d = '0;
            dst_d = dst_q - One;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Game logic sees a dead port while the pass owns the RAM.
  always_comb begin
    if (busy) begin
      mem.rx    = ctl_rx;
      mem.ry    = ctl_ry;
      mem.we    = ctl_we;
      mem.wx    = ctl_wx;
      mem.wy    = ctl_wy;
      mem.wdata = ctl_wdata;
      gl.rdata  = 1'b0;
    end else begin
      mem.rx    = gl.rx;
      mem.ry    = gl.ry;
      mem.we    = gl.we;
      mem.wx    = gl.wx;
      mem.wy    = gl.wy;
      mem.wdata = gl.wdata;
      gl.rdata  = mem.rdata;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= StIdle;
      src_q    <= TopRow;
      dst_q    <= TopRow;
      rowbuf_q <= '0;
      col_q    <= '0;
      lines_q  <= '0;
`ifdef BOARD_CLEAR_EARLY_EXIT_EN
      floor_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rowbuf_q <= rowbuf_d;
      col_q    <= col_d;
      lines_q  <= lines_d;
`ifdef BOARD_CLEAR_EARLY_EXIT_EN
      floor_q  <= floor_d;
`endif
    end
  end

endmodule

// File: doc/board_clear_ctrl.md
Name: board_clear_ctrl

Overview:
- Line-clear controller and board-memory arbiter.
- Sits between the game FSM and the 10x20 board RAM.
- When idle, it passes the game-logic read/write port straight through to the RAM.
- On start (game FSM entering its CLEAR state), it takes ownership of the RAM, removes every full row, compacts the rows above downward, zero-fills the vacated top rows, then pulses done with the number of rows cleared.

Parameters:
- COLS, 10, board width in cells
- ROWS, 20, board height in cells
- X_W, 4, column address width
- Y_W, 5, row address width

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run a clear pass
- busy  out  1  high while the controller owns the RAM
- done  out  1  one-cycle pulse when the pass completes
- lines_cleared  out  3  full rows removed in the last pass; held until the next start
- gl_rx, gl_ry  in  X_W, Y_W  game-logic read address
- gl_rdata  out  1  game-logic read data
- gl_we, gl_wx, gl_wy, gl_wdata  in  1, X_W, Y_W, 1  game-logic write port
- mem_rx, mem_ry  out  X_W, Y_W  RAM read address
- mem_rdata  in  1  RAM read data, valid one cycle after its address
- mem_we, mem_wx, mem_wy, mem_wdata  out  1, X_W, Y_W, 1  RAM write port

Behaviour:
- Reset (synchronous, active-high): state IDLE, busy=0, done=0, lines_cleared=0, src=dst=ROWS-1, internal mem_we=0.
- Arbitration (combinational):
  - busy=0: mem_* = gl_*, gl_rdata = mem_rdata.
  - busy=1: mem_* driven by the controller, gl_rdata=0, gl_we discarded (no write reaches the RAM).
- busy is high exactly when state is not IDLE.
- Internal registers: src and dst are signed Y_W+1 wide; row buffer rowbuf[COLS-1:0]; column counter col.
- IDLE:
  - start=1: src=dst=ROWS-1, lines_cleared=0, col=0, go to READ.
  - start is ignored while busy.
- READ, COLS+1 cycles:
  - Cycle k (k<COLS) drives mem_rx=k, mem_ry=src.
  - Cycle k+1 captures mem_rdata into rowbuf[k].
  - Go to EVAL.
- EVAL, 1 cycle:
  - Row full (&rowbuf): lines_cleared++ (saturating at 7), src--.
  - Else if dst==src: dst--, src--.
  - Else: go to COPY.
  - Then, if the new src<0, go to FILL; otherwise go to READ.
- COPY, COLS cycles:
  - mem_we=1, mem_wy=dst, mem_wx=col, mem_wdata=rowbuf[col].
  - On exit: dst--, src--; if src<0 go to FILL, else go to READ.
- FILL:
  - While dst>=0 (fill_floor in the optional feature): COLS writes of 0 per row, then dst--.
  - Then go to DONE.
- DONE, 1 cycle: done=1, go to IDLE. lines_cleared is stable from DONE onward.
- Controller writes occur only in COPY and FILL, one cell per cycle. mem_rx/mem_ry are don't-care outside READ.
- Boundaries:
  - No full rows: zero writes; done after ROWS*(COLS+2)+1 cycles from start.
  - All rows full: every row is skipped, then FILL zeroes all ROWS rows.
  - Row 0 full: src becomes -1, go to FILL.
  - start and reset in the same cycle: reset wins.
  - Reset mid-pass: the pass is abandoned the next cycle (busy=0, no further writes). The board is left partially compacted; the top level re-initialises it.

Optional Feature:
- Macro: BOARD_CLEAR_EARLY_EXIT_EN.
- Defined: in EVAL, a row with rowbuf==0 means all rows above it are empty. The controller sets fill_floor=src and jumps straight to FILL, which zero-fills rows dst down to src inclusive.
- Undefined: the scan always runs to src<0 and FILL goes down to row 0.
- The resulting board contents are identical in both builds; only the cycle count differs.

Test Plan:
- Empty board, start -> no mem_we pulses, done 241 cycles after start, lines_cleared=0, busy high throughout.
- Row 19 full, cell (3,18) set, rest empty -> afterwards only (3,19) set, lines_cleared=1, one done pulse.
- Rows 16..19 full, cell (0,15) set -> afterwards only (0,19) set, lines_cleared=4.
- Rows 18 and 19 full, (2,17) and (7,16) set -> afterwards (2,19) and (7,18) set, lines_cleared=2.
- Arbitration: idle with gl_we=1 at (5,10) -> RAM cell set the same cycle. While busy, gl_we=1 -> cell unchanged and gl_rdata=0. start pulsed while busy -> no restart, exactly one done.
- Reset asserted on the 3rd COPY cycle -> next cycle busy=0, mem_we=0, lines_cleared=0, state IDLE. A subsequent start runs a normal pass.
